// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared definitions for the BCD conversion blocks.
//                - state_t             : converter FSM states
//                - DEFAULT_DIGITS/BIN_W: default converter geometry
//                - any_digit_invalid() : flags any packed BCD digit above 9.
//                  It is also used on the display side.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int unsigned DEFAULT_DIGITS = 3;
    localparam int unsigned DEFAULT_BIN_W  = 10;

    // Widest packed BCD vector any_digit_invalid() accepts. Narrower callers
    // zero-extend, and zero digits are always valid.
    localparam int unsigned MAX_DIGITS     = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic any_digit_invalid(input logic [4*MAX_DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(MAX_DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adjust
//  Description : Reverse double-dabble digit correction. After a right shift a
//                digit that is 8 or above carries a half-weight bit from the
//                digit above (worth 5, seen as 8), so 3 is removed.
//  Ports       : i_digit [3:0]  shifted BCD digit
//                o_digit [3:0]  corrected digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd8) begin
            o_digit = i_digit - 4'd3;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_to_binary_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_binary_seq
//  Description : Sequential packed-BCD to binary converter (reverse
//                double-dabble, one bit per cycle, 4*DIGITS cycles per
//                conversion regardless of input validity).
//  Ports       : clock             system clock, rising edge
//                reset             synchronous active-high reset
//                start             conversion request, sampled in IDLE only
//                bcd   [4*DIGITS]  packed BCD input, digit 0 in [3:0]
//                busy              high while shifting
//                done              one-cycle pulse when bin/err update
//                bin   [BIN_W]     converted value, held until next done
//                err               an input digit was above 9
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = DEFAULT_DIGITS,
    parameter int unsigned BIN_W  = DEFAULT_BIN_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin,
    output logic                  err
);

    localparam int unsigned ACC_W   = 4 * DIGITS;
    localparam int unsigned COUNT_W = $clog2(ACC_W);

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     sreg_q,  sreg_d;
    logic [ACC_W-1:0]     acc_q,   acc_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 bad_q,   bad_d;
    logic                 done_q,  done_d;
    logic [BIN_W-1:0]     bin_q,   bin_d;
    logic                 err_q,   err_d;

    logic [ACC_W-1:0]        sreg_shift;
    logic [ACC_W-1:0]        sreg_adj;
    logic [ACC_W-1:0]        acc_shift;
    logic [BIN_W-1:0]        acc_bin;
    logic [4*MAX_DIGITS-1:0] bcd_ext;

    // {sreg, acc} shifted right as one register: sreg LSB feeds acc MSB.
    always_comb begin
        sreg_shift = {1'b0, sreg_q[ACC_W-1:1]};
        acc_shift  = {sreg_q[0], acc_q[ACC_W-1:1]};
    end

    generate
        for (genvar gi = 0; gi < int'(DIGITS); gi++) begin : g_digit
            bcd_digit_adjust u_adjust (
                .i_digit (sreg_shift[4*gi +: 4]),
                .o_digit (sreg_adj[4*gi +: 4])
            );
        end
    endgenerate

    // Upper accumulator bits beyond BIN_W are zero for valid input and dropped.
    generate
        if (BIN_W <= ACC_W) begin : g_bin_trunc
            assign acc_bin = acc_shift[BIN_W-1:0];
        end else begin : g_bin_ext
            assign acc_bin = {{(BIN_W-ACC_W){1'b0}}, acc_shift};
        end
    endgenerate

    always_comb begin
        bcd_ext             = '0;
        bcd_ext[ACC_W-1:0]  = bcd;
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        count_d = count_q;
        bad_d   = bad_q;
        bin_d   = bin_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sreg_d  = bcd;
                    acc_d   = '0;
                    count_d = '0;
                    bad_d   = any_digit_invalid(bcd_ext);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sreg_d  = sreg_adj;
                acc_d   = acc_shift;
                count_d = count_q + COUNT_W'(1);
                if (count_q == COUNT_W'(ACC_W - 1)) begin
                    bin_d   = bad_q ? '0 : acc_bin;
                    err_d   = bad_q;
                    done_d  = 1'b1;
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            bad_q   <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            bad_q   <= bad_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = done_q;
    assign bin  = bin_q;
    assign err  = err_q;

endmodule
`default_nettype wire
